// File: rtl/memory_stage_if.sv
// Bundle of execute-side (M) inputs and writeback-side (W) outputs around the MEM stage.
// The master drives the M side and hazard controls; the slave (the stage) drives the W side.
interface memory_stage_if;
  logic        StallW;
  logic        FlushW;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;

  modport master (
    output StallW, FlushW, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M,
    input  RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW
  );

  modport slave (
    input  StallW, FlushW, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M,
    output RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW
  );
endinterface

// File: rtl/memory_stage.sv
// RV32I MEM stage: byte/half/word access to an internal data RAM, followed by the
// MEM/WB pipeline register that feeds writeback directly.
module memory_stage #(
  parameter int DEPTH = 1024
) (
  input logic           clk,
  input logic           rst_n,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rword;
  logic [31:0]   rdata_d;
  logic          unused_addr_hi;

  logic        reg_write_q, result_src_q, misalign_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q, rdata_q, pc4_q;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign idx            = bus.ALU_ResultM[AW+1:2];
  assign boff           = bus.ALU_ResultM[1:0];
  assign unused_addr_hi = ^bus.ALU_ResultM[31:AW+2];

  always_comb begin
    misalign = 1'b0;
    if (bus.MemWriteM || bus.ResultSrcM) begin
      case (bus.funct3M)
        3'b001, 3'b101: misalign = boff[0];
        3'b010:         misalign = |boff;
        default:        misalign = 1'b0;
      endcase
    end
  end

  // Store lanes: data is replicated so each enabled lane picks its own byte.
  always_comb begin
    be     = 4'b0000;
    wlanes = bus.WriteDataM;
    case (bus.funct3M)
      3'b000: begin
        be     = 4'b0001 << boff;
        wlanes = {4{bus.WriteDataM[7:0]}};
      end
      3'b001: begin
        be     = boff[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.WriteDataM[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM is not reset; stores proceed through stalls since rewriting is idempotent.
  always_ff @(posedge clk) begin
    if (bus.MemWriteM && !misalign) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wlanes[8*l +: 8];
      end
    end
  end

  assign rword   = mem_q[idx];
  assign rdata_d = load_extract(bus.funct3M, boff, rword);

  // MEM/WB register boundary: flush beats stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      misalign_q   <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (bus.FlushW) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      misalign_q   <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (!bus.StallW) begin
      reg_write_q  <= bus.RegWriteM & ~misalign;
      result_src_q <= bus.ResultSrcM;
      misalign_q   <= misalign;
      rd_q         <= bus.RdM;
      alu_q        <= bus.ALU_ResultM;
      rdata_q      <= rdata_d;
      pc4_q        <= bus.PCPlus4M;
    end
  end

  assign bus.RegWriteW   = reg_write_q;
  assign bus.ResultSrcW  = result_src_q;
  assign bus.MisalignW   = misalign_q;
  assign bus.RdW         = rd_q;
  assign bus.ALU_ResultW = alu_q;
  assign bus.ReadDataW   = rdata_q;
  assign bus.PCPlus4W    = pc4_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic against a byte-addressed
// reference memory with the MEM/WB register modelled as expected W values.
module tb_memory_stage;
  localparam int DEPTH = 1024;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_stage_if bus ();
  memory_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]  mb [NB];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        eRW, eRS, eMis;
  logic [4:0]  eRd;
  logic [31:0] eALU, eRD, ePC;
  logic [31:0] saved;

  function automatic logic m_mis(input logic mw, input logic rs, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (!(mw || rs)) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int ob, hb, wb, v;
    ob = int'(a % NB);
    hb = ob - (ob % 2);
    wb = ob - (ob % 4);
    case (f3)
      3'b000: begin v = mb[ob]; if (v > 127) v -= 256; return 32'(v); end
      3'b001: begin v = mb[hb] + 256 * mb[hb+1]; if (v > 32767) v -= 65536; return 32'(v); end
      3'b100: return 32'(mb[ob]);
      3'b101: return 32'(mb[hb] + 256 * mb[hb+1]);
      default: return {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RegWriteW"},   32'(bus.RegWriteW),  32'(eRW));
    chk({tag, ".ResultSrcW"},  32'(bus.ResultSrcW), 32'(eRS));
    chk({tag, ".RdW"},         32'(bus.RdW),        32'(eRd));
    chk({tag, ".ALU_ResultW"}, bus.ALU_ResultW,     eALU);
    chk({tag, ".ReadDataW"},   bus.ReadDataW,       eRD);
    chk({tag, ".PCPlus4W"},    bus.PCPlus4W,        ePC);
    chk({tag, ".MisalignW"},   32'(bus.MisalignW),  32'(eMis));
  endtask

  task automatic clear_exp();
    eRW = 0; eRS = 0; eMis = 0; eRd = 0; eALU = 0; eRD = 0; ePC = 0;
  endtask

  task automatic step(input logic st, input logic fl, input logic rw, input logic mw,
                      input logic rs, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                      input string tag);
    logic mis;
    logic [31:0] ld;
    int ob, hb, wb;
    bus.StallW = st; bus.FlushW = fl; bus.RegWriteM = rw; bus.MemWriteM = mw;
    bus.ResultSrcM = rs; bus.funct3M = f3; bus.RdM = rd; bus.ALU_ResultM = a;
    bus.WriteDataM = wd; bus.PCPlus4M = pc;
    mis = m_mis(mw, rs, f3, a);
    ld  = m_load(f3, a);
    if (fl) clear_exp();
    else if (!st) begin
      eRW = rw & ~mis; eRS = rs; eRd = rd; eALU = a; eRD = ld; ePC = pc; eMis = mis;
    end
    if (mw && !mis) begin
      ob = int'(a % NB); hb = ob - (ob % 2); wb = ob - (ob % 4);
      case (f3)
        3'b000: mb[ob] = wd[7:0];
        3'b001: begin mb[hb] = wd[7:0]; mb[hb+1] = wd[15:8]; end
        3'b010: for (int k = 0; k < 4; k++) mb[wb+k] = wd[8*k +: 8];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] ra;
    bus.StallW = 0; bus.FlushW = 0; bus.RegWriteM = 0; bus.MemWriteM = 0;
    bus.ResultSrcM = 0; bus.funct3M = 0; bus.RdM = 0; bus.ALU_ResultM = 0;
    bus.WriteDataM = 0; bus.PCPlus4M = 0;
    clear_exp();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Fill the first 64 words while stalled so W stays at its reset value.
    for (int w = 0; w < 64; w++)
      step(1, 0, 0, 1, 0, 3'b010, 0, 32'(w * 4), $urandom, 0, "init");

    step(0, 0, 0, 1, 0, 3'b010, 5, 32'h10, 32'hDEADBEEF, 32'h104, "t1_sw");
    step(0, 0, 1, 0, 1, 3'b010, 6, 32'h10, 0, 32'h108, "t1_lw");
    chk("t1_lw_lit", bus.ReadDataW, 32'hDEADBEEF);
    chk("t1_rw_lit", 32'(bus.RegWriteW), 32'd1);
    step(0, 0, 1, 0, 1, 3'b000, 7, 32'h13, 0, 32'h10C, "t2_lb");
    chk("t2_lb_lit", bus.ReadDataW, 32'hFFFFFFDE);
    step(0, 0, 1, 0, 1, 3'b100, 7, 32'h13, 0, 32'h110, "t2_lbu");
    chk("t2_lbu_lit", bus.ReadDataW, 32'h000000DE);
    step(0, 0, 1, 0, 1, 3'b001, 7, 32'h12, 0, 32'h114, "t2_lh");
    chk("t2_lh_lit", bus.ReadDataW, 32'hFFFFDEAD);
    step(0, 0, 1, 0, 1, 3'b101, 7, 32'h12, 0, 32'h118, "t2_lhu");
    chk("t2_lhu_lit", bus.ReadDataW, 32'h0000DEAD);

    step(0, 0, 0, 1, 0, 3'b000, 0, 32'h11, 32'hAAAAAA55, 32'h11C, "t3_sb");
    step(0, 0, 1, 0, 1, 3'b010, 8, 32'h10, 0, 32'h120, "t3_lw1");
    chk("t3_lw1_lit", bus.ReadDataW, 32'hDEAD55EF);
    step(0, 0, 0, 1, 0, 3'b001, 0, 32'h12, 32'hBBBB1234, 32'h124, "t3_sh");
    step(0, 0, 1, 0, 1, 3'b010, 8, 32'h10, 0, 32'h128, "t3_lw2");
    chk("t3_lw2_lit", bus.ReadDataW, 32'h123455EF);

    step(0, 0, 1, 0, 1, 3'b010, 9, 32'h12, 0, 32'h12C, "t4_lwmis");
    chk("t4_mis_lit", 32'(bus.MisalignW), 32'd1);
    chk("t4_rw_lit", 32'(bus.RegWriteW), 32'd0);
    saved = m_load(3'b010, 32'h20);
    step(0, 0, 0, 1, 0, 3'b010, 0, 32'h21, 32'h0BADF00D, 32'h130, "t4_swmis");
    step(0, 0, 1, 0, 1, 3'b010, 9, 32'h20, 0, 32'h134, "t4_lw20");
    chk("t4_unchanged", bus.ReadDataW, saved);

    step(0, 0, 1, 0, 1, 3'b010, 10, 32'h10, 0, 32'h138, "t5_pre");
    step(1, 0, 1, 0, 1, 3'b000, 11, 32'h13, 0, 32'h13C, "t5_stall1");
    step(1, 0, 0, 0, 0, 3'b101, 12, 32'h22, 0, 32'h140, "t5_stall2");
    chk("t5_hold_lit", bus.ReadDataW, 32'h123455EF);
    step(1, 1, 1, 0, 1, 3'b010, 13, 32'h14, 0, 32'h144, "t5_flush");

    step(0, 0, 1, 0, 1, 3'b010, 14, 32'h10, 0, 32'h148, "t6_pre");
    @(negedge clk) rst_n = 1'b0;
    #1 clear_exp();
    check_all("t6_rst");
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 3'b010, 0, 32'(NB + 32'h10), 32'hCAFEF00D, 32'h14C, "t6_swalias");
    step(0, 0, 1, 0, 1, 3'b010, 15, 32'h10, 0, 32'h150, "t6_lw");
    chk("t6_alias_lit", bus.ReadDataW, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), 1'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), ra, $urandom, $urandom,
           "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
